// File: rtl/trigger_network_sync_pkg.sv
// Shared types for the network-level trigger synchroniser.
package trigger_network_sync_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        GUARD,
        RUN,
        DONE
    } netstate_t;

    // Cycles after a start broadcast during which stale idle status is ignored.
    localparam int unsigned GUARD_CYCLES = 2;

endpackage

// File: rtl/trigger_network_sync_if.sv
// Status/broadcast bus between the network synchroniser (master) and the trigger array (slave).
interface trigger_network_sync_if #(
    parameter int unsigned NUM_ACTORS = 4
);
    logic                  trig_ap_start;
    logic [NUM_ACTORS-1:0] trig_ap_idle;
    logic [NUM_ACTORS-1:0] trig_sleep;
    logic [NUM_ACTORS-1:0] trig_sync_exec;
    logic [NUM_ACTORS-1:0] trig_sync_wait;
    logic                  external_enqueue;
    logic                  all_sleep;
    logic                  all_sync;
    logic                  all_sync_wait;

    modport master (
        output trig_ap_start, external_enqueue, all_sleep, all_sync, all_sync_wait,
        input  trig_ap_idle, trig_sleep, trig_sync_exec, trig_sync_wait
    );

    modport slave (
        input  trig_ap_start, external_enqueue, all_sleep, all_sync, all_sync_wait,
        output trig_ap_idle, trig_sleep, trig_sync_exec, trig_sync_wait
    );
endinterface

// File: rtl/trigger_status_reduce.sv
// Registered AND-reduction of a per-trigger status vector (1-cycle latency).
module trigger_status_reduce #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] vec,
    output logic         all_q
);
    logic all_d;

    always_comb begin
        all_d = &vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_q <= 1'b0;
        end else begin
            all_q <= all_d;
        end
    end
endmodule

// File: rtl/trigger_network_sync.sv
// Network-level consensus, start broadcast, enqueue tracking and ap_start/ap_done handshake.
// Optional stall watchdog enabled by defining TRIGGER_WATCHDOG_EN.
module trigger_network_sync
    import trigger_network_sync_pkg::*;
#(
    parameter int unsigned NUM_ACTORS      = 4,
    parameter int unsigned NUM_INPUTS      = 2,
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned WATCHDOG_CYCLES = 1024
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic                  ap_idle,
    trigger_network_sync_if.master trig,
    input  logic [NUM_INPUTS-1:0] fifo_wr_en,
    output logic [CNT_W-1:0]      sync_rounds,
    output logic [CNT_W-1:0]      relaunch_count,
    output logic                  deadlock
);
    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    netstate_t         state_q, state_d;
    logic [GW-1:0]     guard_cnt_q, guard_cnt_d;
    logic              ext_q, ext_d;
    logic              sleep_dly_q, sleep_dly_d;
    logic              sync_dly_q, sync_dly_d;
    logic [CNT_W-1:0]  sync_rounds_q, sync_rounds_d;
    logic [CNT_W-1:0]  relaunch_q, relaunch_d;
    logic              all_sleep_q, all_sync_q, all_sync_wait_q, idle_all_q;
    logic [NUM_ACTORS-1:0] sync_vec;
    logic              sleep_rise, sync_rise, start_accept, relaunch_go, wd_trip;

    always_comb begin
        sync_vec = trig.trig_sync_exec | trig.trig_sync_wait;
    end

    trigger_status_reduce #(.N(NUM_ACTORS)) u_red_sleep (
        .clk(ap_clk), .rst_n(ap_rst_n), .vec(trig.trig_sleep), .all_q(all_sleep_q)
    );
    trigger_status_reduce #(.N(NUM_ACTORS)) u_red_sync (
        .clk(ap_clk), .rst_n(ap_rst_n), .vec(sync_vec), .all_q(all_sync_q)
    );
    trigger_status_reduce #(.N(NUM_ACTORS)) u_red_sync_wait (
        .clk(ap_clk), .rst_n(ap_rst_n), .vec(trig.trig_sync_wait), .all_q(all_sync_wait_q)
    );
    trigger_status_reduce #(.N(NUM_ACTORS)) u_red_idle (
        .clk(ap_clk), .rst_n(ap_rst_n), .vec(trig.trig_ap_idle), .all_q(idle_all_q)
    );

    always_comb begin
        state_d      = state_q;
        guard_cnt_d  = guard_cnt_q;
        start_accept = 1'b0;
        relaunch_go  = 1'b0;
        sleep_dly_d  = all_sleep_q;
        sync_dly_d   = all_sync_q;
        sleep_rise   = all_sleep_q & ~sleep_dly_q;
        sync_rise    = all_sync_q & ~sync_dly_q;

        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d      = START;
                    start_accept = 1'b1;
                end
            end
            START: begin
                state_d     = GUARD;
                guard_cnt_d = '0;
            end
            GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    state_d = RUN;
                end else begin
                    guard_cnt_d = guard_cnt_q + GW'(1);
                end
            end
            RUN: begin
                if (idle_all_q) begin
                    if (ext_q) begin
                        state_d     = START;
                        relaunch_go = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else if (wd_trip) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (start_accept) begin
            sync_rounds_d = '0;
            relaunch_d    = '0;
        end else begin
            sync_rounds_d = sync_rounds_q + CNT_W'(sync_rise);
            relaunch_d    = relaunch_q + CNT_W'(relaunch_go);
        end

        // A new write in the same cycle as a clear condition keeps the flag set.
        if (|fifo_wr_en) begin
            ext_d = 1'b1;
        end else if (sleep_rise || relaunch_go) begin
            ext_d = 1'b0;
        end else begin
            ext_d = ext_q;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= IDLE;
            guard_cnt_q   <= '0;
            ext_q         <= 1'b0;
            sleep_dly_q   <= 1'b0;
            sync_dly_q    <= 1'b0;
            sync_rounds_q <= '0;
            relaunch_q    <= '0;
        end else begin
            state_q       <= state_d;
            guard_cnt_q   <= guard_cnt_d;
            ext_q         <= ext_d;
            sleep_dly_q   <= sleep_dly_d;
            sync_dly_q    <= sync_dly_d;
            sync_rounds_q <= sync_rounds_d;
            relaunch_q    <= relaunch_d;
        end
    end

`ifdef TRIGGER_WATCHDOG_EN
    localparam int unsigned SW  = 4 * NUM_ACTORS;
    localparam int unsigned WDW = $clog2(WATCHDOG_CYCLES + 1);

    logic [SW-1:0]  status_q, status_d;
    logic [WDW-1:0] stall_q, stall_d;
    logic           deadlock_q, deadlock_d;
    logic           unchanged;

    always_comb begin
        status_d  = {trig.trig_ap_idle, trig.trig_sleep, trig.trig_sync_exec, trig.trig_sync_wait};
        unchanged = (status_d == status_q);
        wd_trip   = (state_q == RUN) && unchanged && !idle_all_q &&
                    ((32'(stall_q) + 32'd1) == 32'(WATCHDOG_CYCLES));
        if ((state_q == RUN) && unchanged) begin
            stall_d = stall_q + WDW'(1);
        end else begin
            stall_d = '0;
        end
        if (start_accept) begin
            deadlock_d = 1'b0;
        end else begin
            deadlock_d = deadlock_q | wd_trip;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            status_q   <= '0;
            stall_q    <= '0;
            deadlock_q <= 1'b0;
        end else begin
            status_q   <= status_d;
            stall_q    <= stall_d;
            deadlock_q <= deadlock_d;
        end
    end

    assign deadlock = deadlock_q;
`else
    logic wd_unused;

    assign wd_unused = (WATCHDOG_CYCLES != 0);
    assign wd_trip   = 1'b0;
    assign deadlock  = 1'b0;
`endif

    assign ap_done               = (state_q == DONE);
    assign ap_ready              = ap_done;
    assign ap_idle               = (state_q == IDLE);
    assign trig.trig_ap_start    = (state_q == START);
    assign trig.external_enqueue = ext_q;
    assign trig.all_sleep        = all_sleep_q;
    assign trig.all_sync         = all_sync_q;
    assign trig.all_sync_wait    = all_sync_wait_q;
    assign sync_rounds           = sync_rounds_q;
    assign relaunch_count        = relaunch_q;
endmodule
